// File: rtl/mem_rd_pkg.sv
// Shared types and elaboration helpers for the BRAM read-address sequencer.
package mem_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mem_rd_state_t;

    // Cycles needed for the last skewed read to leave the final bank.
    function automatic int drain_cycles(input int n, input int lat);
        return n - 1 + lat;
    endfunction

    // Narrowest drain counter that holds drain_cycles(); kept at least one bit wide.
    function automatic int drain_cnt_w(input int n, input int lat);
        return ($clog2(n + lat) < 1) ? 1 : $clog2(n + lat);
    endfunction

endpackage

// File: rtl/mem_rd_seq.sv
// Read-address sequencer: walks a strided block descriptor for a number of passes,
// drives the head of the BRAM skew chain and pulses done once the chain has drained.
module mem_rd_seq
    import mem_rd_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 12,
    parameter int LAT    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [CNT_W-1:0]  reps_i,
    input  logic              stall_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              first_rd_o,
    output logic              last_rd_o
);

    localparam int DW = drain_cnt_w(N, LAT);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(drain_cycles(N, LAT));

    mem_rd_state_t     state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] stride_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  reps_q;
    logic [ADDR_W-1:0] nxt_addr_q;
    logic [CNT_W-1:0]  in_pass_q;
    logic [CNT_W-1:0]  pass_q;
    logic [DW-1:0]     drain_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              first_q;
    logic              last_q;
    logic              busy_q;
    logic              done_q;

    logic [CNT_W-1:0]  sel_len_s;
    logic [CNT_W-1:0]  sel_reps_s;
    logic [ADDR_W-1:0] sel_base_s;
    logic [ADDR_W-1:0] sel_stride_s;
    logic [CNT_W-1:0]  cur_ip_s;
    logic [CNT_W-1:0]  cur_pass_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic              end_pass_s;
    logic              last_issue_s;
    logic              zero_blk_s;
    logic [CNT_W-1:0]  in_pass_d;
    logic [CNT_W-1:0]  pass_d;
    logic [ADDR_W-1:0] nxt_addr_d;

    // Issue-path view of the descriptor: in IDLE the first read comes straight from the inputs.
    always_comb begin
        if (state_q == IDLE) begin
            sel_len_s    = len_i;
            sel_reps_s   = reps_i;
            sel_base_s   = base_addr_i;
            sel_stride_s = stride_i;
            cur_ip_s     = {CNT_W{1'b0}};
            cur_pass_s   = {CNT_W{1'b0}};
            cur_addr_s   = base_addr_i;
        end else begin
            sel_len_s    = len_q;
            sel_reps_s   = reps_q;
            sel_base_s   = base_q;
            sel_stride_s = stride_q;
            cur_ip_s     = in_pass_q;
            cur_pass_s   = pass_q;
            cur_addr_s   = nxt_addr_q;
        end
    end

    // Counter and address advance for the read being issued this cycle.
    always_comb begin
        zero_blk_s   = (len_i == {CNT_W{1'b0}}) || (reps_i == {CNT_W{1'b0}});
        end_pass_s   = (cur_ip_s == (sel_len_s - CNT_W'(1)));
        last_issue_s = end_pass_s && (cur_pass_s == (sel_reps_s - CNT_W'(1)));
        if (end_pass_s) begin
            in_pass_d  = {CNT_W{1'b0}};
            pass_d     = cur_pass_s + CNT_W'(1);
            nxt_addr_d = sel_base_s;
        end else begin
            in_pass_d  = cur_ip_s + CNT_W'(1);
            pass_d     = cur_pass_s;
            nxt_addr_d = cur_addr_s + sel_stride_s;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            base_q     <= {ADDR_W{1'b0}};
            stride_q   <= {ADDR_W{1'b0}};
            len_q      <= {CNT_W{1'b0}};
            reps_q     <= {CNT_W{1'b0}};
            nxt_addr_q <= {ADDR_W{1'b0}};
            in_pass_q  <= {CNT_W{1'b0}};
            pass_q     <= {CNT_W{1'b0}};
            drain_q    <= {DW{1'b0}};
            rd_en_q    <= 1'b0;
            rd_addr_q  <= {ADDR_W{1'b0}};
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && zero_blk_s) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (start_i) begin
                        base_q     <= base_addr_i;
                        stride_q   <= stride_i;
                        len_q      <= len_i;
                        reps_q     <= reps_i;
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= base_addr_i;
                        first_q    <= 1'b1;
                        last_q     <= last_issue_s;
                        nxt_addr_q <= nxt_addr_d;
                        in_pass_q  <= in_pass_d;
                        pass_q     <= pass_d;
                        busy_q     <= 1'b1;
                        drain_q    <= DRAIN_LOAD;
                        state_q    <= last_issue_s ? DRAIN : READ;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                READ: begin
                    if (!stall_i) begin
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= cur_addr_s;
                        first_q    <= 1'b0;
                        last_q     <= last_issue_s;
                        nxt_addr_q <= nxt_addr_d;
                        in_pass_q  <= in_pass_d;
                        pass_q     <= pass_d;
                        drain_q    <= DRAIN_LOAD;
                        state_q    <= last_issue_s ? DRAIN : READ;
                    end else begin
                        state_q <= READ;
                    end
                end
                DRAIN: begin
                    if (drain_q == {DW{1'b0}}) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_q <= drain_q - DW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rd_en_o    = rd_en_q;
    assign rd_addr_o  = rd_addr_q;
    assign first_rd_o = first_q;
    assign last_rd_o  = last_q;

endmodule
